// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle main controller and the MIPS datapath.
// The controller connects through the master modport, the datapath through slave.
// Optional macro CTRL_PERF_CNT_EN adds the instr_count/stall_count counters.
interface multicycle_controller_if #(
    parameter int OP_W = 4
);
    logic [5:0]      opc;
    logic [5:0]      func;
    logic            mem_ready;
    logic            RegDest;
    logic            RegisterWrite;
    logic            ALUSource;
    logic            ALUSource2;
    logic            RegSel;
    logic            WriteMem;
    logic            ReadMem;
    logic            MemToReg;
    logic            Branch;
    logic [OP_W-1:0] operation;
    logic            pc_write;
    logic            ir_write;
    logic            illegal;
    logic            mem_abort;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]     instr_count;
    logic [31:0]     stall_count;
`endif

    modport master (
        input  opc, input func, input mem_ready,
`ifdef CTRL_PERF_CNT_EN
        output instr_count, output stall_count,
`endif
        output RegDest, output RegisterWrite, output ALUSource, output ALUSource2,
        output RegSel, output WriteMem, output ReadMem, output MemToReg,
        output Branch, output operation, output pc_write, output ir_write,
        output illegal, output mem_abort
    );

    modport slave (
        output opc, output func, output mem_ready,
`ifdef CTRL_PERF_CNT_EN
        input  instr_count, input stall_count,
`endif
        input  RegDest, input RegisterWrite, input ALUSource, input ALUSource2,
        input  RegSel, input WriteMem, input ReadMem, input MemToReg,
        input  Branch, input operation, input pc_write, input ir_write,
        input  illegal, input mem_abort
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM for the 32-bit MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues exactly
// one pc_write per instruction. MEM waits on mem_ready with an optional timeout.
// Optional macro CTRL_PERF_CNT_EN adds instruction and stall counters.
module multicycle_controller #(
    parameter int OP_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {K_ALU, K_SHIFT, K_LW, K_SW, K_BEQ, K_ADDI} kind_t;

    localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state, state_nx;
    kind_t           dec_kind, kind_r;
    logic [OP_W-1:0] dec_op, op_r;
    logic            dec_ok;
    logic [TW-1:0]   tcnt;
    logic            timed_out;

    logic RegDest_c, RegisterWrite_c, ALUSource_c, ALUSource2_c, RegSel_c;
    logic WriteMem_c, ReadMem_c, MemToReg_c, Branch_c;
    logic pc_write_c, ir_write_c, illegal_c, mem_abort_c;
    logic [OP_W-1:0] operation_c;

    // Abort fires once the waiting-cycle count has reached the limit.
    assign timed_out = (MEM_TIMEOUT != 0) && (tcnt == TW'(MEM_TIMEOUT));

    // Classify opc/func into an instruction kind and ALU operation.
    always_comb begin
        dec_ok   = 1'b1;
        dec_kind = K_ALU;
        dec_op   = OP_AND;
        case (bus.opc)
            6'b000000: begin
                case (bus.func)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b000000: begin dec_kind = K_SHIFT; dec_op = OP_SLL; end
                    6'b000010: begin dec_kind = K_SHIFT; dec_op = OP_SRL; end
                    default:   dec_ok = 1'b0;
                endcase
            end
            6'b100011: begin dec_kind = K_LW;   dec_op = OP_ADD; end
            6'b101011: begin dec_kind = K_SW;   dec_op = OP_ADD; end
            6'b000100: begin dec_kind = K_BEQ;  dec_op = OP_SUB; end
            6'b001000: begin dec_kind = K_ADDI; dec_op = OP_ADD; end
            default:   dec_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Instruction class captured in DECODE; only read after it has been written.
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            kind_r <= dec_kind;
            op_r   <= dec_op;
        end
    end

    // MEM wait counter: counts cycles without mem_ready, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (state == S_MEM && !bus.mem_ready && !timed_out)
            tcnt <= tcnt + TW'(1);
        else
            tcnt <= '0;
    end

    // Next-state logic.
    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = dec_ok ? S_EXEC : S_FETCH;
            S_EXEC: begin
                case (kind_r)
                    K_BEQ:       state_nx = S_FETCH;
                    K_LW, K_SW:  state_nx = S_MEM;
                    default:     state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (timed_out)          state_nx = S_FETCH;
                else if (bus.mem_ready) state_nx = (kind_r == K_LW) ? S_WB : S_FETCH;
                else                    state_nx = S_MEM;
            end
            default:  state_nx = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        RegDest_c = 1'b0; RegisterWrite_c = 1'b0; ALUSource_c = 1'b0;
        ALUSource2_c = 1'b0; RegSel_c = 1'b0; WriteMem_c = 1'b0; ReadMem_c = 1'b0;
        MemToReg_c = 1'b0; Branch_c = 1'b0; operation_c = '0; pc_write_c = 1'b0;
        ir_write_c = 1'b0; illegal_c = 1'b0; mem_abort_c = 1'b0;
        if (!rst) begin
            if (state == S_EXEC || state == S_WB) begin
                if (kind_r == K_ALU || kind_r == K_SHIFT) begin
                    ALUSource_c = 1'b1;
                    RegDest_c   = 1'b1;
                end
                if (kind_r == K_SHIFT) begin
                    ALUSource2_c = 1'b1;
                    RegSel_c     = 1'b1;
                end
            end
            case (state)
                S_FETCH:  ir_write_c = 1'b1;
                S_DECODE: begin
                    illegal_c  = !dec_ok;
                    pc_write_c = !dec_ok;
                end
                S_EXEC: begin
                    operation_c = op_r;
                    if (kind_r == K_BEQ) begin
                        ALUSource_c = 1'b1;
                        Branch_c    = 1'b1;
                        pc_write_c  = 1'b1;
                    end
                end
                S_MEM: begin
                    operation_c = op_r;
                    if (timed_out) begin
                        mem_abort_c = 1'b1;
                        pc_write_c  = 1'b1;
                    end else begin
                        ReadMem_c  = (kind_r == K_LW);
                        MemToReg_c = (kind_r == K_LW);
                        WriteMem_c = (kind_r == K_SW);
                        pc_write_c = (kind_r == K_SW) && bus.mem_ready;
                    end
                end
                S_WB: begin
                    operation_c     = op_r;
                    MemToReg_c      = (kind_r == K_LW);
                    RegisterWrite_c = 1'b1;
                    pc_write_c      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.RegDest       = RegDest_c;
    assign bus.RegisterWrite = RegisterWrite_c;
    assign bus.ALUSource     = ALUSource_c;
    assign bus.ALUSource2    = ALUSource2_c;
    assign bus.RegSel        = RegSel_c;
    assign bus.WriteMem      = WriteMem_c;
    assign bus.ReadMem       = ReadMem_c;
    assign bus.MemToReg      = MemToReg_c;
    assign bus.Branch        = Branch_c;
    assign bus.operation     = operation_c;
    assign bus.pc_write      = pc_write_c;
    assign bus.ir_write      = ir_write_c;
    assign bus.illegal       = illegal_c;
    assign bus.mem_abort     = mem_abort_c;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_cnt, stall_cnt;

    // Retired-instruction and memory-stall counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_write_c)                         instr_cnt <= instr_cnt + 32'd1;
            if (state == S_MEM && !bus.mem_ready)   stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.instr_count = instr_cnt;
    assign bus.stall_count = stall_cnt;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control vectors, and a
// compare process checks the DUT against them every cycle.
module tb_multicycle_controller;
    localparam int OP_W = 4;
    localparam int T    = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_controller_if #(.OP_W(OP_W)) bus ();
    multicycle_controller #(.OP_W(OP_W), .MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic RegDest, RegisterWrite, ALUSource, ALUSource2, RegSel;
        logic WriteMem, ReadMem, MemToReg, Branch;
        logic [3:0] operation;
        logic pc_write, ir_write, illegal, mem_abort;
    } vec_t;

    vec_t  exp_q[$];
    vec_t  plan_v[$];
    logic  plan_rdy[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    string cur_name = "reset";

    function automatic vec_t observed();
        vec_t v;
        v.RegDest = bus.RegDest;     v.RegisterWrite = bus.RegisterWrite;
        v.ALUSource = bus.ALUSource; v.ALUSource2 = bus.ALUSource2;
        v.RegSel = bus.RegSel;       v.WriteMem = bus.WriteMem;
        v.ReadMem = bus.ReadMem;     v.MemToReg = bus.MemToReg;
        v.Branch = bus.Branch;       v.operation = bus.operation;
        v.pc_write = bus.pc_write;   v.ir_write = bus.ir_write;
        v.illegal = bus.illegal;     v.mem_abort = bus.mem_abort;
        return v;
    endfunction

    // Per-cycle compare against the model's expected vector.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e, a;
            e = exp_q.pop_front();
            a = observed();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs %s cycle %0d: got %h want %h", cur_name, cyc, a, e);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Instruction table: 0 alu, 1 shift, 2 lw, 3 sw, 4 beq, 5 addi, -1 unsupported.
    function automatic int classify(input logic [5:0] o, input logic [5:0] f, output logic [3:0] op);
        op = 4'b0000;
        if (o == 6'b000000) begin
            if (f == 6'b100000) begin op = 4'b0010; return 0; end
            if (f == 6'b100010) begin op = 4'b0110; return 0; end
            if (f == 6'b100100) begin op = 4'b0000; return 0; end
            if (f == 6'b100101) begin op = 4'b0001; return 0; end
            if (f == 6'b101010) begin op = 4'b0111; return 0; end
            if (f == 6'b000000) begin op = 4'b0011; return 1; end
            if (f == 6'b000010) begin op = 4'b0100; return 1; end
            return -1;
        end
        if (o == 6'b100011) begin op = 4'b0010; return 2; end
        if (o == 6'b101011) begin op = 4'b0010; return 3; end
        if (o == 6'b000100) begin op = 4'b0110; return 4; end
        if (o == 6'b001000) begin op = 4'b0010; return 5; end
        return -1;
    endfunction

    // Expand one instruction into expected vectors and the mem_ready to drive.
    // low = number of MEM cycles with mem_ready low before it rises.
    task automatic plan(input logic [5:0] o, input logic [5:0] f, input int low);
        vec_t v, sel;
        logic [3:0] op;
        int k, waits;
        plan_v.delete();
        plan_rdy.delete();
        k = classify(o, f, op);
        v = '0; v.ir_write = 1'b1;
        plan_v.push_back(v); plan_rdy.push_back(1'b0);
        v = '0;
        if (k < 0) begin
            v.illegal = 1'b1; v.pc_write = 1'b1;
            plan_v.push_back(v); plan_rdy.push_back(1'b0);
            return;
        end
        plan_v.push_back(v); plan_rdy.push_back(1'b0);
        sel = '0; sel.operation = op;
        if (k == 0 || k == 1) begin sel.RegDest = 1'b1; sel.ALUSource = 1'b1; end
        if (k == 1) begin sel.ALUSource2 = 1'b1; sel.RegSel = 1'b1; end
        v = sel;
        if (k == 4) begin
            v.ALUSource = 1'b1; v.Branch = 1'b1; v.pc_write = 1'b1;
            plan_v.push_back(v); plan_rdy.push_back(1'b0);
            return;
        end
        plan_v.push_back(v); plan_rdy.push_back(1'b0);
        if (k == 2 || k == 3) begin
            waits = (low >= T) ? T : low;
            v = sel;
            if (k == 2) begin v.ReadMem = 1'b1; v.MemToReg = 1'b1; end
            else        v.WriteMem = 1'b1;
            for (int i = 0; i < waits; i++) begin
                plan_v.push_back(v); plan_rdy.push_back(1'b0);
            end
            if (low >= T) begin
                v = sel; v.mem_abort = 1'b1; v.pc_write = 1'b1;
                plan_v.push_back(v); plan_rdy.push_back(1'b0);
                return;
            end
            if (k == 3) v.pc_write = 1'b1;
            plan_v.push_back(v); plan_rdy.push_back(1'b1);
            if (k == 3) return;
        end
        v = sel; v.RegisterWrite = 1'b1; v.pc_write = 1'b1;
        if (k == 2) v.MemToReg = 1'b1;
        plan_v.push_back(v); plan_rdy.push_back(1'b0);
    endtask

    // Run one instruction; stop_after > 0 cuts it short (for mid-instruction reset).
    task automatic run(input string name, input logic [5:0] o, input logic [5:0] f,
                       input int low, input int lit_cycles, input int lit_strobes,
                       input int lit_op, input int lit_stalls, input int stop_after);
        int n, pcw_cnt, pcw_cyc, strobes, exec_op;
`ifdef CTRL_PERF_CNT_EN
        int ic0, sc0;
        ic0 = int'(bus.instr_count);
        sc0 = int'(bus.stall_count);
`endif
        plan(o, f, low);
        cur_name = name;
        n = (stop_after > 0) ? stop_after : plan_v.size();
        pcw_cnt = 0; pcw_cyc = 0; strobes = 0; exec_op = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.opc = o;
            bus.func = f;
            bus.mem_ready = plan_rdy[i];
            cyc = i + 1;
            exp_q.push_back(plan_v[i]);
            @(negedge clk);
            #1;
            if (bus.pc_write) begin pcw_cnt++; pcw_cyc = i + 1; end
            if (bus.ReadMem || bus.WriteMem) strobes++;
            if (i == 2) exec_op = int'(bus.operation);
        end
        if (stop_after == 0) begin
            chk({name, " model_len"}, plan_v.size(), lit_cycles);
            chk({name, " pc_write_cycle"}, pcw_cyc, lit_cycles);
            chk({name, " pc_write_count"}, pcw_cnt, 1);
            chk({name, " strobe_cycles"}, strobes, lit_strobes);
            if (lit_op >= 0) chk({name, " exec_op"}, exec_op, lit_op);
`ifdef CTRL_PERF_CNT_EN
            chk({name, " instr_count_delta"}, int'(bus.instr_count) - ic0, 1);
            chk({name, " stall_count_delta"}, int'(bus.stall_count) - sc0, lit_stalls);
`else
            if (lit_stalls < 0) chk({name, " stall_arg"}, lit_stalls, 0);
`endif
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            bus.mem_ready = 1'b0;
            cur_name = "reset";
            cyc = i + 1;
            exp_q.push_back('0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opc = 6'b000000;
        bus.func = 6'b100000;
        bus.mem_ready = 1'b0;
        reset_cycles(2);
        //   name        opc        func       low  cyc str  op  stalls
        run("add",      6'b000000, 6'b100000, 0,   4,  0,  2,  0, 0);
        run("lw_wait3", 6'b100011, 6'b000000, 3,   8,  4,  2,  3, 0);
        run("beq",      6'b000100, 6'b000000, 0,   3,  0,  6,  0, 0);
        run("sll",      6'b000000, 6'b000000, 0,   4,  0,  3,  0, 0);
        run("srl",      6'b000000, 6'b000010, 0,   4,  0,  4,  0, 0);
        run("illegal",  6'b111111, 6'b000000, 0,   2,  0, -1,  0, 0);
        run("sw_stuck", 6'b101011, 6'b000000, 99, 19, 15,  2, 16, 0);
        run("sw",       6'b101011, 6'b000000, 0,   4,  1,  2,  0, 0);
        run("lw",       6'b100011, 6'b000000, 0,   5,  1,  2,  0, 0);
        run("addi",     6'b001000, 6'b000000, 0,   4,  0,  2,  0, 0);
        run("sub",      6'b000000, 6'b100010, 0,   4,  0,  6,  0, 0);
        run("and",      6'b000000, 6'b100100, 0,   4,  0,  0,  0, 0);
        run("or",       6'b000000, 6'b100101, 0,   4,  0,  1,  0, 0);
        run("slt",      6'b000000, 6'b101010, 0,   4,  0,  7,  0, 0);
        run("bad_func", 6'b000000, 6'b111111, 0,   2,  0, -1,  0, 0);
        run("sw_lw_pre",6'b101011, 6'b000000, 2,   6,  3,  2,  2, 0);
        // Reset in the middle of a stalled store, then a clean add must follow.
        run("sw_cut",   6'b101011, 6'b000000, 99, 0,  0,  2,  0, 8);
        reset_cycles(2);
`ifdef CTRL_PERF_CNT_EN
        chk("instr_count_after_reset", int'(bus.instr_count), 0);
        chk("stall_count_after_reset", int'(bus.stall_count), 0);
`endif
        run("add_after_rst", 6'b000000, 6'b100000, 0, 4, 0, 2, 0, 0);
        @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
